// File: rtl/judge_line_scan.sv
// Scans a board line in 5-cell windows, one per cycle, and accumulates a saturating pattern score.
// Define JUDGE_OPEN_END_EN to double 3/4-stone windows whose two outer neighbours are empty.
module judge_line_scan #(
   parameter int LINE_LEN = 15,
   parameter int SCORE_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [LINE_LEN-1:0] own,
   input  logic [LINE_LEN-1:0] opp,
   output logic                busy,
   output logic                done,
   output logic [2:0]          best_type,
   output logic [4:0]          best_pos,
   output logic [SCORE_W-1:0]  score
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   localparam logic [4:0]       LAST_P = 5'(LINE_LEN - 5);
   localparam int               ACC_W  = ((SCORE_W > 15) ? SCORE_W : 15) + 1;
   localparam logic [ACC_W-1:0] SAT    = (ACC_W'(1) << SCORE_W) - ACC_W'(1);

   state_t                state_q, state_d;
   logic [LINE_LEN-1:0]   own_q, own_d, opp_q, opp_d;
   logic [4:0]            p_q, p_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic [2:0]            best_type_q, best_type_d;
   logic [4:0]            best_pos_q, best_pos_d;
   logic [SCORE_W-1:0]    score_q, score_d;
   // Second pipeline stage: one evaluated window waiting to be accumulated.
   logic                  win_vld_q, win_vld_d, win_last_q, win_last_d;
   logic [2:0]            win_k_q, win_k_d;
   logic [14:0]           win_w_q, win_w_d;
   logic [4:0]            win_pos_q, win_pos_d;

   logic [4:0]            own_win, opp_win;
   logic [2:0]            k;
   logic                  live;
   logic [14:0]           w;
   logic [ACC_W-1:0]      sum;
`ifdef JUDGE_OPEN_END_EN
   logic [LINE_LEN+1:0]   occ_w;
   logic                  open_end;
`endif

   always_comb begin
      own_win = 5'(own_q >> p_q);
      opp_win = 5'(opp_q >> p_q);
      live    = (opp_win == 5'd0);
      k       = 3'd0;
      for (int i = 0; i < 5; i++) begin
         k = k + 3'(own_win[i]);
      end
      case (k)
         3'd1:    w = 15'd1;
         3'd2:    w = 15'd10;
         3'd3:    w = 15'd100;
         3'd4:    w = 15'd1000;
         3'd5:    w = 15'd10000;
         default: w = 15'd0;
      endcase
`ifdef JUDGE_OPEN_END_EN
      // Guard bits on both ends so cells p-1 and p+5 land at bits 0 and 6.
      occ_w    = {1'b0, own_q | opp_q, 1'b0} >> p_q;
      open_end = (p_q != 5'd0) && (p_q < LAST_P) && !occ_w[0] && !occ_w[6]
                 && ((k == 3'd3) || (k == 3'd4));
      if (open_end) begin
         w = w << 1;
      end
`endif
      sum = ACC_W'(score_q) + ACC_W'(win_w_q);
   end

   always_comb begin
      state_d     = state_q;
      own_d       = own_q;
      opp_d       = opp_q;
      p_d         = p_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      best_type_d = best_type_q;
      best_pos_d  = best_pos_q;
      score_d     = score_q;
      win_vld_d   = 1'b0;
      win_last_d  = 1'b0;
      win_k_d     = win_k_q;
      win_w_d     = win_w_q;
      win_pos_d   = win_pos_q;
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d     = S_SCAN;
               busy_d      = 1'b1;
               own_d       = own;
               opp_d       = opp;
               p_d         = 5'd0;
               best_type_d = 3'd0;
               best_pos_d  = 5'd0;
               score_d     = '0;
            end
         end
         S_SCAN: begin
            win_vld_d  = 1'b1;
            win_last_d = (p_q == LAST_P);
            win_k_d    = live ? k : 3'd0;
            win_w_d    = live ? w : 15'd0;
            win_pos_d  = p_q;
            if (p_q != LAST_P) begin
               p_d = p_q + 5'd1;
            end
            if (win_vld_q) begin
               score_d = (sum > SAT) ? SCORE_W'(SAT) : SCORE_W'(sum);
               // Strict compare keeps the earliest window on ties.
               if (win_k_q > best_type_q) begin
                  best_type_d = win_k_q;
                  best_pos_d  = win_pos_q;
               end
               if (win_last_q) begin
                  state_d   = S_DONE;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  win_vld_d = 1'b0;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         own_q       <= '0;
         opp_q       <= '0;
         p_q         <= 5'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         best_type_q <= 3'd0;
         best_pos_q  <= 5'd0;
         score_q     <= '0;
         win_vld_q   <= 1'b0;
         win_last_q  <= 1'b0;
         win_k_q     <= 3'd0;
         win_w_q     <= 15'd0;
         win_pos_q   <= 5'd0;
      end else begin
         state_q     <= state_d;
         own_q       <= own_d;
         opp_q       <= opp_d;
         p_q         <= p_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         best_type_q <= best_type_d;
         best_pos_q  <= best_pos_d;
         score_q     <= score_d;
         win_vld_q   <= win_vld_d;
         win_last_q  <= win_last_d;
         win_k_q     <= win_k_d;
         win_w_q     <= win_w_d;
         win_pos_q   <= win_pos_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign best_type = best_type_q;
   assign best_pos  = best_pos_q;
   assign score     = score_q;

endmodule
